imem_loader: RTL and testbench

//  Writer side of the instruction-memory interface the core fetches from.

---
 rtl/imem_loader.sv | 118 +++++++++++
 tb/tb_imem_loader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction RAM: assembles little-endian words and holds the core until loaded.
// Optional trailing XOR checksum byte enabled by defining CHECKSUM_EN.
module imem_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

`ifdef CHECKSUM_EN
  typedef enum logic [2:0] {S_INIT, S_HDR, S_LOAD, S_CSUM, S_DONE, S_ERROR} state_t;
`else
  typedef enum logic [2:0] {S_INIT, S_HDR, S_LOAD, S_DONE, S_ERROR} state_t;
`endif

  state_t      state;
  logic [7:0]  last;
  logic [1:0]  lane;
  logic [23:0] partial;
  logic        last_word;
`ifdef CHECKSUM_EN
  logic [7:0]  csum;
`endif

`ifdef CHECKSUM_EN
  assign in_ready = (state == S_HDR) || (state == S_LOAD) || (state == S_CSUM);
`else
  assign in_ready = (state == S_HDR) || (state == S_LOAD);
`endif
  assign cpu_hold  = ~done;
  // waddr tracks the word being assembled; it is updated well before the next word completes
  assign last_word = (8'(waddr) == last);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_INIT;
      we      <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
      done    <= 1'b0;
      error   <= 1'b0;
      last    <= '0;
      lane    <= '0;
      partial <= '0;
`ifdef CHECKSUM_EN
      csum    <= '0;
`endif
    end else begin
      we <= 1'b0;
      // Final word leaves waddr at N-1 so it never runs past the program
      if (we && !last_word)
        waddr <= waddr + ADDR_W'(1);
      case (state)
        S_INIT: state <= S_HDR;
        S_HDR: if (in_valid) begin
          if (in_data == 8'd0) begin
`ifdef CHECKSUM_EN
            state <= S_CSUM;
`else
            state <= S_DONE;
            done  <= 1'b1;
`endif
          end else if (int'(in_data) > DEPTH) begin
            state <= S_ERROR;
            error <= 1'b1;
          end else begin
            last  <= in_data - 8'd1;
            state <= S_LOAD;
          end
        end
        S_LOAD: if (in_valid) begin
`ifdef CHECKSUM_EN
          csum <= csum ^ in_data;
`endif
          lane <= lane + 2'd1;
          if (lane == 2'd3) begin
            wdata <= {in_data, partial};
            we    <= 1'b1;
            if (last_word) begin
`ifdef CHECKSUM_EN
              state <= S_CSUM;
`else
              state <= S_DONE;
`endif
            end
          end else begin
            partial[8*lane +: 8] <= in_data;
          end
        end
`ifdef CHECKSUM_EN
        S_CSUM: if (in_valid) begin
          if (in_data == csum) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state <= S_ERROR;
            error <= 1'b1;
          end
        end
`endif
        S_DONE:  done <= 1'b1;
        S_ERROR: error <= 1'b1;
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: cycle-by-cycle vector table plus gap/reset sequences.
// Define CHECKSUM_EN to exercise the checksum build instead of the cycle table.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, we, cpu_hold, done, error;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  imem_loader #(.DEPTH(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .we(we), .waddr(waddr), .wdata(wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned cyc = 0;
  logic [4:0]  we_a[$];
  logic [31:0] we_d[$];
  int unsigned we_c[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (we === 1'b1) begin
    we_a.push_back(waddr);
    we_d.push_back(wdata);
    we_c.push_back(cyc);
  end

  typedef struct {
    bit r; bit v; logic [7:0] d; bit chk;
    bit rdy; bit we; logic [4:0] a; logic [31:0] wd; bit dn; bit er;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic add(input bit r, input bit v, input logic [7:0] d, input bit c,
                     input bit rdy, input bit w, input logic [4:0] a,
                     input logic [31:0] wd, input bit dn, input bit er);
    vec_t e;
    e = '{r, v, d, c, rdy, w, a, wd, dn, er};
    tbl.push_back(e);
  endtask

  task automatic reset_dut();
    @(negedge clk); rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int unsigned gap);
    repeat (gap) begin @(negedge clk); in_valid = 1'b0; end
    @(negedge clk); in_valid = 1'b1; in_data = b;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin @(negedge clk); in_valid = 1'b0; end
    #1;
  endtask

  localparam logic [31:0] W1  = 32'h005303B3;
  localparam logic [31:0] W2A = 32'h44332211;
  localparam logic [31:0] W2B = 32'h88776655;

  initial begin
    logic [7:0] pay[8];
    int unsigned gaps[9];
    pay  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    gaps = '{0, 2, 1, 3, 0, 1, 2, 0, 1};

    rst = 1'b1;
    repeat (2) @(negedge clk);

`ifndef CHECKSUM_EN
    // single word, then done
    add(0,0,8'h00,1, 0,0,0,0,0,0);
    add(0,1,8'h01,1, 1,0,0,0,0,0);
    add(0,1,8'hB3,1, 1,0,0,0,0,0);
    add(0,1,8'h03,1, 1,0,0,0,0,0);
    add(0,1,8'h53,1, 1,0,0,0,0,0);
    add(0,1,8'h00,1, 1,0,0,0,0,0);
    add(0,0,8'h00,1, 0,1,0,W1,0,0);
    add(0,1,8'hAA,1, 0,0,0,W1,1,0);
    add(0,0,8'h00,1, 0,0,0,W1,1,0);
    // empty program
    add(1,0,8'h00,0, 0,0,0,0,0,0);
    add(1,0,8'h00,1, 0,0,0,0,0,0);
    add(0,1,8'h00,1, 0,0,0,0,0,0);
    add(0,1,8'h00,1, 1,0,0,0,0,0);
    add(0,0,8'h00,1, 0,0,0,0,1,0);
    add(0,1,8'h05,1, 0,0,0,0,1,0);
    // oversize header
    add(1,0,8'h00,0, 0,0,0,0,0,0);
    add(0,0,8'h00,1, 0,0,0,0,0,0);
    add(0,1,8'h21,1, 1,0,0,0,0,0);
    add(0,1,8'h01,1, 0,0,0,0,0,1);
    add(0,1,8'hB3,1, 0,0,0,0,0,1);
    add(0,0,8'h00,1, 0,0,0,0,0,1);
    // two words back to back: we pulses 4 cycles apart
    add(1,0,8'h00,0, 0,0,0,0,0,0);
    add(0,0,8'h00,1, 0,0,0,0,0,0);
    add(0,1,8'h02,1, 1,0,0,0,0,0);
    add(0,1,8'h11,1, 1,0,0,0,0,0);
    add(0,1,8'h22,1, 1,0,0,0,0,0);
    add(0,1,8'h33,1, 1,0,0,0,0,0);
    add(0,1,8'h44,1, 1,0,0,0,0,0);
    add(0,1,8'h55,1, 1,1,0,W2A,0,0);
    add(0,1,8'h66,1, 1,0,1,W2A,0,0);
    add(0,1,8'h77,1, 1,0,1,W2A,0,0);
    add(0,1,8'h88,1, 1,0,1,W2A,0,0);
    add(0,0,8'h00,1, 0,1,1,W2B,0,0);
    add(0,0,8'h00,1, 0,0,1,W2B,1,0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst = tbl[i].r; in_valid = tbl[i].v; in_data = tbl[i].d;
      #1;
      if (tbl[i].chk) begin
        chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
        chk($sformatf("v%0d.we", i),       32'(we),       32'(tbl[i].we));
        chk($sformatf("v%0d.waddr", i),    32'(waddr),    32'(tbl[i].a));
        chk($sformatf("v%0d.wdata", i),    wdata,         tbl[i].wd);
        chk($sformatf("v%0d.done", i),     32'(done),     32'(tbl[i].dn));
        chk($sformatf("v%0d.error", i),    32'(error),    32'(tbl[i].er));
        chk($sformatf("v%0d.cpu_hold", i), 32'(cpu_hold), 32'(!tbl[i].dn));
      end
    end
`endif

    // two words with random-looking in_valid gaps
    reset_dut();
    we_a.delete(); we_d.delete(); we_c.delete();
    send(8'h02, gaps[0]);
    for (int i = 0; i < 8; i++) send(pay[i], gaps[i+1]);
`ifdef CHECKSUM_EN
    send(8'h88, 1);
`endif
    idle(3);
    chk("gap.we_count", 32'(we_a.size()), 32'd2);
    if (we_a.size() == 2) begin
      chk("gap.addr0", 32'(we_a[0]), 32'd0);
      chk("gap.data0", we_d[0], W2A);
      chk("gap.addr1", 32'(we_a[1]), 32'd1);
      chk("gap.data1", we_d[1], W2B);
    end
    chk("gap.done", 32'(done), 32'd1);
    chk("gap.error", 32'(error), 32'd0);

    // reset in the middle of a word discards it
    reset_dut();
    we_a.delete(); we_d.delete(); we_c.delete();
    send(8'h01, 0); send(8'h12, 0); send(8'h34, 0);
    @(negedge clk); in_valid = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.we", 32'(we), 32'd0);
    chk("rst.waddr", 32'(waddr), 32'd0);
    chk("rst.wdata", wdata, 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.error", 32'(error), 32'd0);
    chk("rst.cpu_hold", 32'(cpu_hold), 32'd1);
    send(8'h01, 0); send(8'h9A, 0); send(8'hBC, 0); send(8'hDE, 0); send(8'hF0, 0);
`ifdef CHECKSUM_EN
    send(8'h08, 0);
`endif
    idle(3);
    chk("reload.we_count", 32'(we_a.size()), 32'd1);
    if (we_a.size() == 1) begin
      chk("reload.addr", 32'(we_a[0]), 32'd0);
      chk("reload.data", we_d[0], 32'hF0DEBC9A);
    end
    chk("reload.done", 32'(done), 32'd1);
    chk("reload.cpu_hold", 32'(cpu_hold), 32'd0);

`ifdef CHECKSUM_EN
    reset_dut();
    we_a.delete(); we_d.delete(); we_c.delete();
    send(8'h01, 0); send(8'hB3, 0); send(8'h03, 0); send(8'h53, 0); send(8'h00, 0);
    send(8'hE3, 0);
    idle(2);
    chk("csum_ok.done", 32'(done), 32'd1);
    chk("csum_ok.error", 32'(error), 32'd0);
    chk("csum_ok.cpu_hold", 32'(cpu_hold), 32'd0);
    reset_dut();
    we_a.delete(); we_d.delete(); we_c.delete();
    send(8'h01, 0); send(8'hB3, 0); send(8'h03, 0); send(8'h53, 0); send(8'h00, 0);
    send(8'h00, 0);
    idle(2);
    chk("csum_bad.done", 32'(done), 32'd0);
    chk("csum_bad.error", 32'(error), 32'd1);
    chk("csum_bad.cpu_hold", 32'(cpu_hold), 32'd1);
    chk("csum_bad.we_count", 32'(we_a.size()), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
